// File: rtl/qser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qser_pkg
// Description : Shared types and default sizes for the quantizer/serializer
//               packer (state encoding, job configuration record).
// Revision    : 1.0 - initial release
// ============================================================================
package qser_pkg;

    localparam int QS_N        = 64;
    localparam int QS_BWIN     = 32;
    localparam int QS_BWMSBIDX = $clog2(QS_BWIN);
    localparam int QS_BWPREC   = $clog2(QS_BWIN) + 1;
    localparam int QS_BWNVEC   = 16;
    localparam int QS_BWADDR   = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAITIN = 2'd1,
        ST_EMIT   = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    typedef struct packed {
        logic [QS_BWMSBIDX-1:0] msbidx;
        logic [QS_BWPREC-1:0]   prec;
        logic [QS_BWNVEC-1:0]   nvec;
        logic [QS_BWADDR-1:0]   baseaddr;
    } cfg_t;

endpackage : qser_pkg
`default_nettype wire

// File: rtl/qser_packer_agu.sv
`default_nettype none
// ============================================================================
// Module      : qser_packer_agu
// Description : Write-address generator with bit-plane and vector counters,
//               flagging the last plane of a vector and the last vector.
// Revision    : 1.0 - initial release
// ============================================================================
module qser_packer_agu
    import qser_pkg::*;
#(
    parameter int BWPREC = QS_BWPREC,
    parameter int BWNVEC = QS_BWNVEC,
    parameter int BWADDR = QS_BWADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    input  logic [BWADDR-1:0] i_base,
    input  logic [BWPREC-1:0] i_prec,
    input  logic [BWNVEC-1:0] i_nvec,
    input  logic              i_load,
    input  logic              i_fire,
    output logic [BWADDR-1:0] o_addr,
    output logic              o_last_plane,
    output logic              o_last_vec
);

    localparam logic [BWPREC-1:0] c_PREC_ONE = BWPREC'(1);
    localparam logic [BWNVEC-1:0] c_NVEC_ONE = BWNVEC'(1);
    localparam logic [BWADDR-1:0] c_ADDR_ONE = BWADDR'(1);

    logic [BWADDR-1:0] r_addr;
    logic [BWPREC-1:0] r_plane;
    logic [BWNVEC-1:0] r_vec;
    logic              w_last_plane;
    logic              w_last_vec;

    // prec and nvec are guaranteed non-zero while a job is running
    assign w_last_plane = (r_plane == (i_prec - c_PREC_ONE));
    assign w_last_vec   = (r_vec   == (i_nvec - c_NVEC_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_plane <= '0;
            r_vec   <= '0;
        end else begin
            if (i_init) begin
                r_addr <= i_base;
                r_vec  <= '0;
            end else if (i_fire) begin
                r_addr <= r_addr + c_ADDR_ONE;
                if (w_last_plane) begin
                    r_vec <= r_vec + c_NVEC_ONE;
                end
            end

            if (i_load) begin
                r_plane <= '0;
            end else if (i_fire) begin
                r_plane <= r_plane + c_PREC_ONE;
            end
        end
    end

    assign o_addr       = r_addr;
    assign o_last_plane = w_last_plane;
    assign o_last_vec   = w_last_vec;

endmodule : qser_packer_agu
`default_nettype wire

// File: rtl/qser_packer.sv
`default_nettype none
// ============================================================================
// Module      : qser_packer
// Description : Sequences a bank of bit-serial serializer lanes and packs one
//               bit per lane per step into bit-plane words written to memory.
//               Optional cycle counters enabled by QSER_PACKER_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module qser_packer
    import qser_pkg::*;
#(
    parameter int N        = QS_N,
    parameter int BWIN     = QS_BWIN,
    parameter int BWMSBIDX = $clog2(BWIN),
    parameter int BWPREC   = $clog2(BWIN) + 1,
    parameter int BWNVEC   = QS_BWNVEC,
    parameter int BWADDR   = QS_BWADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BWMSBIDX-1:0] cfg_msbidx,
    input  logic [BWPREC-1:0]   cfg_prec,
    input  logic [BWNVEC-1:0]   cfg_nvec,
    input  logic [BWADDR-1:0]   cfg_baseaddr,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                qs_load,
    output logic                qs_step,
    output logic [BWMSBIDX-1:0] qs_msbidx,
    input  logic [N-1:0]        qs_bits,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [BWADDR-1:0]   wr_addr,
    output logic [N-1:0]        wr_data,
    output logic                busy,
    output logic                done
`ifdef QSER_PACKER_PERF_EN
    ,
    output logic [31:0]         perf_stall,
    output logic [31:0]         perf_wait
`endif
);

    state_t            r_state;
    state_t            w_next;
    cfg_t              r_cfg;
    logic              r_init;
    logic              w_start_idle;
    logic              w_accept;
    logic              w_fire;
    logic [BWADDR-1:0] w_addr;
    logic              w_last_plane;
    logic              w_last_vec;

    assign w_start_idle = (r_state == ST_IDLE) && start;
    assign w_accept     = w_start_idle && (cfg_nvec != '0) && (cfg_prec != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cfg   <= '0;
            r_init  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_init  <= w_accept;
            if (w_accept) begin
                r_cfg <= '{msbidx:   cfg_msbidx,
                           prec:     cfg_prec,
                           nvec:     cfg_nvec,
                           baseaddr: cfg_baseaddr};
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        qs_load  = 1'b0;
        qs_step  = 1'b0;
        wr_valid = 1'b0;
        w_fire   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = w_accept ? ST_WAITIN : ST_FIN;
                end
            end
            ST_WAITIN: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                qs_load  = in_valid;
                if (in_valid) begin
                    w_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                busy     = 1'b1;
                wr_valid = 1'b1;
                w_fire   = wr_ready;
                // Stepping on the accepting edge keeps qs_bits frozen under backpressure
                qs_step  = wr_ready;
                if (wr_ready && w_last_plane) begin
                    w_next = w_last_vec ? ST_FIN : ST_WAITIN;
                end
            end
            ST_FIN: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Address is seeded on the first WAITIN cycle, before any write can fire
    qser_packer_agu #(
        .BWPREC (BWPREC),
        .BWNVEC (BWNVEC),
        .BWADDR (BWADDR)
    ) u_agu (
        .clk          (clk),
        .rst          (rst),
        .i_init       (r_init),
        .i_base       (r_cfg.baseaddr),
        .i_prec       (r_cfg.prec),
        .i_nvec       (r_cfg.nvec),
        .i_load       (qs_load),
        .i_fire       (w_fire),
        .o_addr       (w_addr),
        .o_last_plane (w_last_plane),
        .o_last_vec   (w_last_vec)
    );

    assign qs_msbidx = r_cfg.msbidx;
    assign wr_addr   = wr_valid ? w_addr  : '0;
    assign wr_data   = wr_valid ? qs_bits : '0;

`ifdef QSER_PACKER_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_wait;

    always_ff @(posedge clk) begin
        if (rst || w_start_idle) begin
            r_perf_stall <= '0;
            r_perf_wait  <= '0;
        end else begin
            if (wr_valid && !wr_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if ((r_state == ST_WAITIN) && !in_valid && (r_perf_wait != '1)) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
        end
    end

    assign perf_stall = r_perf_stall;
    assign perf_wait  = r_perf_wait;
`endif

endmodule : qser_packer
`default_nettype wire

// File: tb/tb_qser_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_qser_packer
// Description : Scoreboard bench for qser_packer with a behavioural serializer
//               bank feeding qs_bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qser_packer;

    localparam int N      = 64;
    localparam int BWIN   = 32;
    localparam int BWMSB  = 5;
    localparam int BWPREC = 6;
    localparam int BWNVEC = 16;
    localparam int BWADDR = 15;

    typedef struct packed {
        logic [BWADDR-1:0] addr;
        logic [N-1:0]      data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [BWMSB-1:0]  cfg_msbidx = '0;
    logic [BWPREC-1:0] cfg_prec = '0;
    logic [BWNVEC-1:0] cfg_nvec = '0;
    logic [BWADDR-1:0] cfg_baseaddr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              qs_load;
    logic              qs_step;
    logic [BWMSB-1:0]  qs_msbidx;
    logic [N-1:0]      qs_bits;
    logic              wr_valid;
    logic              wr_ready = 1'b1;
    logic [BWADDR-1:0] wr_addr;
    logic [N-1:0]      wr_data;
    logic              busy;
    logic              done;
`ifdef QSER_PACKER_PERF_EN
    logic [31:0]       perf_stall;
    logic [31:0]       perf_wait;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_loads  = 0;
    int n_writes = 0;
    exp_t exp_q[$];
    logic [BWIN-1:0] din  [N];
    logic [BWIN-1:0] sreg [N];
    logic [BWADDR-1:0] exp_addr;

    always #5 clk = ~clk;

    qser_packer u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_msbidx   (cfg_msbidx),
        .cfg_prec     (cfg_prec),
        .cfg_nvec     (cfg_nvec),
        .cfg_baseaddr (cfg_baseaddr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .qs_load      (qs_load),
        .qs_step      (qs_step),
        .qs_msbidx    (qs_msbidx),
        .qs_bits      (qs_bits),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done)
`ifdef QSER_PACKER_PERF_EN
        ,
        .perf_stall   (perf_stall),
        .perf_wait    (perf_wait)
`endif
    );

    // Serializer bank: load din, shift left on step, emit the bit at msbidx
    always @(posedge clk) begin
        for (int l = 0; l < N; l++) begin
            if (qs_load)      sreg[l] <= din[l];
            else if (qs_step) sreg[l] <= sreg[l] << 1;
        end
    end

    always_comb begin
        qs_bits = '0;
        for (int l = 0; l < N; l++) qs_bits[l] = sreg[l][qs_msbidx];
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] plane_word(input int p, input int msb);
        logic [N-1:0] w;
        w = '0;
        for (int l = 0; l < N; l++) w[l] = (p <= msb) ? din[l][msb - p] : 1'b0;
        return w;
    endfunction

    // Output monitor: pops the scoreboard on every accepted write
    logic          prev_stall = 1'b0;
    logic [N-1:0]  prev_data;
    logic [BWADDR-1:0] prev_addr;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("load_step_excl", 64'(qs_load & qs_step), 64'd0);
            chk("step_is_fire", 64'(qs_step), 64'(wr_valid & wr_ready));
            chk("ready_vs_valid", 64'(in_ready & wr_valid), 64'd0);
            if (qs_load) n_loads++;
            if (prev_stall && wr_valid) begin
                chk("stall_data_stable", wr_data, prev_data);
                chk("stall_addr_stable", 64'(wr_addr), 64'(prev_addr));
            end
            if (wr_valid && wr_ready) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                    chk("wr_data", wr_data, e.data);
                end
            end
        end
        prev_stall = wr_valid & ~wr_ready;
        prev_data  = wr_data;
        prev_addr  = wr_addr;
    end

    task automatic run_job(input int msb, input int prec, input int nvec, input int base,
                           input int stall_plane, input int stall_len,
                           input int gap_vec, input int gap_len, input logic [BWIN-1:0] lane0);
        int k;
        cfg_msbidx   = BWMSB'(msb);
        cfg_prec     = BWPREC'(prec);
        cfg_nvec     = BWNVEC'(nvec);
        cfg_baseaddr = BWADDR'(base);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble cfg inputs mid-job; the latched copy must be used
        cfg_msbidx = ~cfg_msbidx; cfg_prec = '0; cfg_nvec = '0; cfg_baseaddr = ~cfg_baseaddr;
        chk("busy_after_start", 64'(busy), 64'd1);
        exp_addr = BWADDR'(base);
        for (int v = 0; v < nvec; v++) begin
            if (v == gap_vec) begin
                in_valid = 1'b0;
                repeat (gap_len) begin
                    chk("in_ready_gap", 64'(in_ready), 64'd1);
                    @(posedge clk); #1;
                end
            end
            chk("in_ready_waitin", 64'(in_ready), 64'd1);
            chk("qs_msbidx", 64'(qs_msbidx), 64'(msb));
            for (int l = 0; l < N; l++) din[l] = $urandom;
            din[0] = lane0;
            in_valid = 1'b1;
            for (int p = 0; p < prec; p++) begin
                exp_q.push_back('{addr: exp_addr, data: plane_word(p, msb)});
                exp_addr = exp_addr + 1'b1;
            end
            @(posedge clk); #1;
            chk("wr_valid_after_load", 64'(wr_valid), 64'd1);
            for (int p = 0; p < prec; p++) begin
                k = 0;
                while (!wr_valid && k < 20) begin
                    @(posedge clk); #1;
                    k++;
                end
                if (k >= 20) chk("wr_valid_timeout", 64'd1, 64'd0);
                if (p == stall_plane) begin
                    wr_ready = 1'b0;
                    repeat (stall_len) @(posedge clk);
                    #1;
                    wr_ready = 1'b1;
                end
                @(posedge clk); #1;
            end
            if (v == nvec - 1) in_valid = 1'b0;
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_in_fin", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("done_cleared", 64'(done), 64'd0);
        chk("busy_cleared", 64'(busy), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_degenerate(input int prec, input int nvec);
        int ld0, wr0;
        logic seen;
        ld0 = n_loads; wr0 = n_writes; seen = 1'b0;
        cfg_prec = BWPREC'(prec); cfg_nvec = BWNVEC'(nvec); cfg_msbidx = 5'd7;
        in_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("degen_done", 64'(seen), 64'd1);
        chk("degen_idle", 64'(busy), 64'd0);
        chk("degen_no_load", 64'(n_loads - ld0), 64'd0);
        chk("degen_no_write", 64'(n_writes - wr0), 64'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;
        for (int l = 0; l < N; l++) begin din[l] = '0; sreg[l] = '0; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_qs_msbidx", 64'(qs_msbidx), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic job
        run_job(7, 8, 1, 'h100, -1, 0, -1, 0, 32'hA5);
        // Backpressure at plane 2
        run_job(7, 8, 1, 'h100, 2, 3, -1, 0, 32'hA5);
`ifdef QSER_PACKER_PERF_EN
        chk("perf_stall", 64'(perf_stall), 64'd3);
`endif
        // Multi-vector with input gap before the second vector
        run_job(9, 4, 3, 'h40, -1, 0, 1, 5, 32'h0000_0355);
`ifdef QSER_PACKER_PERF_EN
        chk("perf_wait", 64'(perf_wait), 64'd5);
`endif
        // Precision beyond msbidx+1 yields trailing zero planes
        run_job(2, 6, 1, 'h300, -1, 0, -1, 0, 32'h7);
        // Address wrap
        run_job(31, 4, 1, 'h7FFE, 0, 2, -1, 0, 32'hDEAD_BEEF);
        run_degenerate(0, 4);
        run_degenerate(4, 0);

        // Reset mid-EMIT at plane 3
        cfg_msbidx = 5'd7; cfg_prec = 6'd8; cfg_nvec = 16'd1; cfg_baseaddr = 15'h200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int l = 0; l < N; l++) din[l] = $urandom;
        exp_addr = 15'h200;
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back('{addr: exp_addr, data: plane_word(p, 7)});
            exp_addr = exp_addr + 1'b1;
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_wr_addr", 64'(wr_addr), 64'h203);
        rst = 1'b1; wr_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; wr_ready = 1'b1;
        exp_q.delete();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_wr_valid", 64'(wr_valid), 64'd0);
        chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
        chk("midrst_wr_data", wr_data, 64'd0);
        chk("midrst_qs_msbidx", 64'(qs_msbidx), 64'd0);
        chk("midrst_ctrl", 64'({in_ready, qs_load, qs_step}), 64'd0);
        saw_done = 1'b0;
        repeat (4) begin
            saw_done = saw_done | done;
            @(posedge clk); #1;
        end
        chk("midrst_no_done", 64'(saw_done), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_qser_packer
`default_nettype wire
